store_req_unit: RTL

//  Store-side data-SRAM master: takes one store command per handshake from the EXE stage and

---
 rtl/store_req_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/store_req_unit.sv
// store_req_unit: store-side data-SRAM master.
// Accepts one store command per handshake, checks alignment, builds byte
// strobes and lane-aligned write data for SB/SH/SW/SWL/SWR, and drives a
// req/addr_ok/data_ok bus with at most one transaction outstanding.
//
// Ports
//   clk, resetn                  clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready          command handshake from EXE
//   cmd_type/cmd_vaddr/cmd_rt    store kind, effective address, rt value
//   flush                        cancels the pending store
//   data_req..data_wdata         bus request fields (held stable in REQ)
//   data_addr_ok, data_data_ok   bus address accept / write complete
//   done_valid                   1-cycle pulse on completed, uncancelled store
//   ades_valid, ades_badvaddr    misaligned store pulse and faulting address
//
// state | meaning
// IDLE  | ready for a command
// REQ   | data_req asserted, waiting for data_addr_ok
// WAIT  | address accepted, waiting for data_data_ok
module store_req_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_type,
  input  logic [ADDR_W-1:0] cmd_vaddr,
  input  logic [DATA_W-1:0] cmd_rt,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  output logic              done_valid,
  output logic              ades_valid,
  output logic [ADDR_W-1:0] ades_badvaddr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_nxt;
  logic   cancel;

  logic              accept;
  logic              is_sh, is_sw, misalign;
  logic [1:0]        off;
  logic [4:0]        swl_shift, swr_shift;
  logic [1:0]        lane_size;
  logic [3:0]        lane_strb;
  logic [DATA_W-1:0] lane_wdata;
  logic [ADDR_W-1:0] lane_addr;

  assign off       = cmd_vaddr[1:0];
  assign is_sh     = (cmd_type == 3'd1);
  // Undefined encodings 5..7 behave as SW, including the alignment check.
  assign is_sw     = (cmd_type == 3'd2) || (cmd_type >= 3'd5);
  assign misalign  = (is_sh && off[0]) || (is_sw && (off != 2'b00));
  assign accept    = (state == IDLE) && cmd_valid && !flush;
  assign swl_shift = {2'd3 - off, 3'b000};
  assign swr_shift = {off, 3'b000};

  always_comb begin
    lane_size  = 2'd2;
    lane_strb  = 4'b1111;
    lane_wdata = cmd_rt;
    lane_addr  = cmd_vaddr;
    case (cmd_type)
      3'd0: begin
        lane_size  = 2'd0;
        lane_strb  = 4'b0001 << off;
        lane_wdata = {4{cmd_rt[7:0]}};
      end
      3'd1: begin
        lane_size  = 2'd1;
        lane_strb  = off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{cmd_rt[15:0]}};
      end
      3'd3: begin
        // SWL writes the high bytes of rt into the low lanes up to off.
        lane_addr  = {cmd_vaddr[ADDR_W-1:2], 2'b00};
        lane_strb  = 4'b1111 >> (2'd3 - off);
        lane_wdata = cmd_rt >> swl_shift;
      end
      3'd4: begin
        // SWR writes the low bytes of rt into lanes from off upwards.
        lane_addr  = {cmd_vaddr[ADDR_W-1:2], 2'b00};
        lane_strb  = 4'b1111 << off;
        lane_wdata = cmd_rt << swr_shift;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !misalign) state_nxt = REQ;
      REQ:  if (data_addr_ok)        state_nxt = WAIT;
      WAIT: if (data_data_ok)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign data_req  = (state == REQ);
  assign data_wr   = data_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_size     <= '0;
      data_addr     <= '0;
      data_wstrb    <= '0;
      data_wdata    <= '0;
      done_valid    <= 1'b0;
      ades_valid    <= 1'b0;
      ades_badvaddr <= '0;
      cancel        <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      ades_valid <= 1'b0;
      if (accept && misalign) begin
        ades_valid    <= 1'b1;
        ades_badvaddr <= cmd_vaddr;
      end
      if (accept && !misalign) begin
        data_size  <= lane_size;
        data_addr  <= lane_addr;
        data_wstrb <= lane_strb;
        data_wdata <= lane_wdata;
      end
      // A request already on the bus cannot be withdrawn; flush only
      // suppresses its completion pulse.
      if (state == WAIT && data_data_ok) begin
        done_valid <= !cancel && !flush;
        cancel     <= 1'b0;
      end else if (flush && state != IDLE) begin
        cancel <= 1'b1;
      end
    end
  end

endmodule
